// File: rtl/dmem_lsu.sv
// Byte-lane data memory with a load/store front end: lane steering, sign/zero
// extension, misalignment detection and a single-entry registered response.
module dmem_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);
  localparam int IDX_W = ADDR_W - OFS_W;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  word_idx;
  logic [OFS_W-1:0]  offset;
  logic [OFS_W+2:0]  shift_amt;
  int                acc_bytes;
  int                keep_bits;
  int                sign_pos;
  logic              misaligned;
  logic              illegal;
  logic              req_err;
  logic              accept;
  logic              wr_en;
  logic [LANES-1:0]  wr_mask;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_shifted;
  logic [DATA_W-1:0] ld_val;
  logic              fill_bit;

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // FSM: state register, next-state logic, outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = accept ? S_RESP : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (state == S_RESP);
    req_ready = ~rsp_valid | rsp_ready;
  end

  // An accept edge that coincides with reset must not touch the array.
  assign accept = req_valid & req_ready & rst_n;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign word_idx  = req_addr[ADDR_W-1:OFS_W];
  assign offset    = req_addr[OFS_W-1:0];
  assign shift_amt = {offset, 3'b000};

  always_comb begin
    acc_bytes  = 1 << req_size;
    keep_bits  = (8 * acc_bytes > DATA_W) ? DATA_W : 8 * acc_bytes;
    sign_pos   = keep_bits - 1;
    illegal    = acc_bytes > LANES;
    misaligned = (int'(offset) & (acc_bytes - 1)) != 0;
    req_err    = illegal | misaligned;
  end

  assign wr_en = accept & req_we & ~req_err;

  // ---------------------------------------------------------------------------
  // Store path: lane mask and store data replicated across the word
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_mask = '0;
    wr_data = '0;
    for (int l = 0; l < LANES; l++) begin
      wr_mask[l]        = (l >= int'(offset)) && (l < int'(offset) + acc_bytes);
      wr_data[8*l +: 8] = req_wdata[8*(l & (acc_bytes - 1)) +: 8];
    end
  end

  // NOTE: the storage array has no reset; contents survive rst_n and only the
  // response registers are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_mask[l]) mem[word_idx][8*l +: 8] <= wr_data[8*l +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load path: asynchronous array read, shift down, then extend
  // ---------------------------------------------------------------------------
  assign rd_word    = mem[word_idx];
  assign rd_shifted = rd_word >> shift_amt;
  assign fill_bit   = ~req_unsigned & rd_shifted[sign_pos];

  // A full-width access keeps every bit, so req_unsigned has no effect there.
  always_comb begin
    ld_val = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ld_val[i] = (i < keep_bits) ? rd_shifted[i] : fill_bit;
    end
  end

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= (req_we || req_err) ? '0 : ld_val;
      rsp_err   <= req_err;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a 32-bit and a 64-bit instance driven in
// lockstep with shared request fields, checked against hand-computed values.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_ready;

  logic        req_ready32, rsp_valid32, rsp_err32;
  logic [31:0] rsp_rdata32;
  logic        req_ready64, rsp_valid64, rsp_err64;
  logic [63:0] rsp_rdata64;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] got32;
  logic        gerr32;
  logic [63:0] got64;
  logic        gerr64;
  logic        gvalid;

  always #5 clk = ~clk;

  dmem_lsu #(.DATA_W(32), .ADDR_W(12)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready32), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata32), .rsp_err(rsp_err32)
  );

  dmem_lsu #(.DATA_W(64), .ADDR_W(12)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready64), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata64), .rsp_err(rsp_err64)
  );

  // One accepted request with rsp_ready high; the response is captured on the
  // falling edge right after the accept edge (one-cycle latency).
  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [11:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    rsp_ready    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    got32  = rsp_rdata32;
    gerr32 = rsp_err32;
    got64  = rsp_rdata64;
    gerr64 = rsp_err64;
    gvalid = rsp_valid32 & rsp_valid64;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid32 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rsp_valid32); end
    n_checks++; if (rsp_rdata32 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata32); end
    n_checks++; if (rsp_err32 !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", rsp_err32); end
    n_checks++; if (req_ready32 !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", req_ready32); end
    n_checks++; if (rsp_valid64 !== 1'b0) begin n_fail++; $display("FAIL reset_valid64 got %b exp 0", rsp_valid64); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    xact(1'b1, 2'd2, 1'b0, 12'h010, 64'h0000_0000_DEAD_BEEF);
    n_checks++; if (gvalid !== 1'b1) begin n_fail++; $display("FAIL st_word_latency got %b exp 1", gvalid); end
    n_checks++; if (got32 !== 32'h0 || gerr32 !== 1'b0) begin n_fail++; $display("FAIL st_word_rsp got %h/%b exp 0/0", got32, gerr32); end
    xact(1'b0, 2'd2, 1'b0, 12'h010, 64'h0);
    n_checks++; if (gvalid !== 1'b1) begin n_fail++; $display("FAIL ld_word_latency got %b exp 1", gvalid); end
    n_checks++; if (got32 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_word got %h exp deadbeef", got32); end
    n_checks++; if (gerr32 !== 1'b0) begin n_fail++; $display("FAIL ld_word_err got %b exp 0", gerr32); end
  endtask

  task automatic test_byte();
    xact(1'b1, 2'd0, 1'b0, 12'h013, 64'h0000_0000_0000_005A);
    xact(1'b0, 2'd0, 1'b1, 12'h013, 64'h0);
    n_checks++; if (got32 !== 32'h0000005A) begin n_fail++; $display("FAIL ld_ubyte got %h exp 0000005a", got32); end
    xact(1'b0, 2'd2, 1'b0, 12'h010, 64'h0);
    n_checks++; if (got32 !== 32'h5AADBEEF) begin n_fail++; $display("FAIL ld_word_merged got %h exp 5aadbeef", got32); end
    n_checks++; if (got64 !== 64'h0000_0000_5AAD_BEEF) begin n_fail++; $display("FAIL ld_word_merged64 got %h exp 5aadbeef", got64); end
    xact(1'b0, 2'd0, 1'b0, 12'h012, 64'h0);
    n_checks++; if (got32 !== 32'hFFFFFFAD) begin n_fail++; $display("FAIL ld_sbyte got %h exp ffffffad", got32); end
  endtask

  task automatic test_half();
    xact(1'b0, 2'd1, 1'b0, 12'h012, 64'h0);
    n_checks++; if (got32 !== 32'h00005AAD) begin n_fail++; $display("FAIL ld_shalf_pos got %h exp 00005aad", got32); end
    xact(1'b0, 2'd1, 1'b1, 12'h010, 64'h0);
    n_checks++; if (got32 !== 32'h0000BEEF) begin n_fail++; $display("FAIL ld_uhalf got %h exp 0000beef", got32); end
    xact(1'b0, 2'd1, 1'b0, 12'h010, 64'h0);
    n_checks++; if (got32 !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL ld_shalf_neg got %h exp ffffbeef", got32); end
  endtask

  task automatic test_misaligned();
    xact(1'b1, 2'd1, 1'b0, 12'h011, 64'h0000_0000_0000_1234);
    n_checks++; if (gerr32 !== 1'b1 || got32 !== 32'h0) begin n_fail++; $display("FAIL st_half_misal got %h/%b exp 0/1", got32, gerr32); end
    n_checks++; if (gerr64 !== 1'b1 || got64 !== 64'h0) begin n_fail++; $display("FAIL st_half_misal64 got %h/%b exp 0/1", got64, gerr64); end
    xact(1'b0, 2'd2, 1'b0, 12'h010, 64'h0);
    n_checks++; if (got32 !== 32'h5AADBEEF) begin n_fail++; $display("FAIL mem_unchanged got %h exp 5aadbeef", got32); end
    xact(1'b0, 2'd2, 1'b0, 12'h012, 64'h0);
    n_checks++; if (gerr32 !== 1'b1 || got32 !== 32'h0) begin n_fail++; $display("FAIL ld_word_misal got %h/%b exp 0/1", got32, gerr32); end
    xact(1'b0, 2'd3, 1'b0, 12'h010, 64'h0);
    n_checks++; if (gerr32 !== 1'b1 || got32 !== 32'h0) begin n_fail++; $display("FAIL size3_illegal got %h/%b exp 0/1", got32, gerr32); end
    n_checks++; if (gerr64 !== 1'b0) begin n_fail++; $display("FAIL size3_legal64 err got %b exp 0", gerr64); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 12'h010; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_size = 2'd0; req_unsigned = 1'b1; req_addr = 12'h013;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (req_ready32 !== 1'b0 || req_ready64 !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", i, req_ready32); end
      n_checks++; if (rsp_valid32 !== 1'b1 || rsp_rdata32 !== 32'h5AADBEEF || rsp_err32 !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d] got %b/%h/%b exp 1/5aadbeef/0", i, rsp_valid32, rsp_rdata32, rsp_err32); end
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready32 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", req_ready32); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (rsp_valid32 !== 1'b1 || rsp_rdata32 !== 32'h0000005A) begin n_fail++; $display("FAIL b2b_first got %b/%h exp 1/0000005a", rsp_valid32, rsp_rdata32); end
    req_size = 2'd1; req_unsigned = 1'b0; req_addr = 12'h010;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (rsp_valid32 !== 1'b1 || rsp_rdata32 !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL b2b_second got %b/%h exp 1/ffffbeef", rsp_valid32, rsp_rdata32); end
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (rsp_valid32 !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", rsp_valid32); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 12'h010; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b1; req_wdata = 64'h1111_1111_1111_1111;
    n_checks++; if (rsp_valid32 !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid got %b exp 1", rsp_valid32); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid32 !== 1'b0 || rsp_valid64 !== 1'b0) begin n_fail++; $display("FAIL rmid_async_drop got %b/%b exp 0/0", rsp_valid32, rsp_valid64); end
    n_checks++; if (rsp_rdata32 !== 32'h0) begin n_fail++; $display("FAIL rmid_rdata got %h exp 0", rsp_rdata32); end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    xact(1'b0, 2'd2, 1'b0, 12'h010, 64'h0);
    n_checks++; if (got32 !== 32'h5AADBEEF) begin n_fail++; $display("FAIL rmid_preserved got %h exp 5aadbeef", got32); end
    n_checks++; if (got64 !== 64'h0000_0000_5AAD_BEEF) begin n_fail++; $display("FAIL rmid_preserved64 got %h exp 5aadbeef", got64); end
  endtask

  task automatic test_wide();
    xact(1'b1, 2'd3, 1'b0, 12'h008, 64'h0123_4567_89AB_CDEF);
    n_checks++; if (gerr64 !== 1'b0 || got64 !== 64'h0) begin n_fail++; $display("FAIL st_double got %h/%b exp 0/0", got64, gerr64); end
    n_checks++; if (gerr32 !== 1'b1) begin n_fail++; $display("FAIL st_double32_err got %b exp 1", gerr32); end
    xact(1'b0, 2'd2, 1'b0, 12'h00C, 64'h0);
    n_checks++; if (got64 !== 64'h0000_0000_0123_4567) begin n_fail++; $display("FAIL ld_word_hi64 got %h exp 0000000001234567", got64); end
    xact(1'b0, 2'd0, 1'b0, 12'h00F, 64'h0);
    n_checks++; if (got64 !== 64'h0000_0000_0000_0001) begin n_fail++; $display("FAIL ld_byte_top64 got %h exp 0000000000000001", got64); end
    xact(1'b0, 2'd3, 1'b1, 12'h008, 64'h0);
    n_checks++; if (got64 !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL ld_double got %h exp 0123456789abcdef", got64); end
    xact(1'b0, 2'd2, 1'b0, 12'h008, 64'h0);
    n_checks++; if (got64 !== 64'hFFFF_FFFF_89AB_CDEF) begin n_fail++; $display("FAIL ld_sword64 got %h exp ffffffff89abcdef", got64); end
    xact(1'b0, 2'd2, 1'b1, 12'h008, 64'h0);
    n_checks++; if (got64 !== 64'h0000_0000_89AB_CDEF) begin n_fail++; $display("FAIL ld_uword64 got %h exp 0000000089abcdef", got64); end
    xact(1'b0, 2'd3, 1'b0, 12'h00C, 64'h0);
    n_checks++; if (gerr64 !== 1'b1 || got64 !== 64'h0) begin n_fail++; $display("FAIL ld_double_misal got %h/%b exp 0/1", got64, gerr64); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_backpressure();
    test_reset_mid();
    test_wide();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
